carry_lookahead_adder: RTL and testbench
========================================

// Module: carry_lookahead_adder
// PURPOSE
//   WIDTH-bit adder with carry-in/carry-out, built from carry-lookahead logic rather than ripple carry.
//   Operands are added combinationally; sum and carry-out are captured in output registers.
//   General arithmetic leaf block for datapaths needing a registered A+B+cin with bounded carry depth.
// PARAMETERS
//   WIDTH   4   operand/sum width in bits; must be a multiple of 4 (one lookahead group per nibble)
// PORTS
//   clk       input   1      single clock; all state updates on rising edge
//   rst       input   1      reset, asynchronous, active-high
//   Y         output  WIDTH  registered sum, low WIDTH bits of A+B+carryin
//   carryout  output  1      registered carry out of MSB (bit WIDTH of A+B+carryin)
//   A         input   WIDTH  operand A, unsigned
//   B         input   WIDTH  operand B, unsigned
//   carryin   input   1      carry into bit 0
//   Positional order for instantiation after clk,rst: Y, carryout, A, B, carryin.
// BEHAVIOUR
//   - Per bit: g[i]=A[i]&B[i], p[i]=A[i]^B[i]; sum[i]=p[i]^c[i]; c[0]=carryin.
//   - Within each 4-bit group, carries are two-level lookahead:
//     c1=g0|p0c0, c2=g1|p1g0|p1p0c0, c3=..., c4=group G | group P & c0.
//   - Group G/P feed a second-level lookahead unit across groups (WIDTH>4); no bit-to-bit ripple.
//   - {carryout,Y} registered on posedge clk = A+B+carryin (WIDTH+1-bit exact result).
//   - Latency: exactly 1 cycle from input change (sampled at edge) to outputs; new result every cycle.
//   - No handshake, no state machine; inputs are sampled every cycle unconditionally.
//   - Reset: rst=1 asynchronously forces Y=0, carryout=0 immediately, held while rst=1.
//     First result after rst deasserts reflects inputs at the first rising edge with rst=0.
//   - Wrap-around: results >= 2**WIDTH wrap in Y, with carryout=1 (e.g. 15+15+1 -> Y=15, cout=1).
//   - Max case all-ones+all-ones+1 must produce Y=all-ones, carryout=1.
//   - X/Z on inputs is not specified; no internal state beyond the output register.
// CONFIGURATION
//   CLA_OVERFLOW_EN defined: adds output port 'overflow' (1 bit, registered, reset 0) =
//     signed overflow = c[WIDTH]^c[WIDTH-1], treating A,B as two's complement.
//   CLA_OVERFLOW_EN undefined: port and its logic are absent; all else identical.
// STRUCTURE
//   Package cla_pkg: CLA_GROUP_W=4 constant, default WIDTH, gp_t struct {g,p} for group signals.
//   Sub-module cla_group4: 4-bit slice; inputs a[3:0], b[3:0], cin; outputs sum[3:0], G, P.
//   Top: generate WIDTH/4 cla_group4 instances, second-level lookahead carry unit, output register.
// TESTING
//   1. rst=1 with A=9,B=9,carryin=1 -> Y=0,carryout=0 immediately and while held, regardless of clk.
//   2. A=0,B=0,carryin=0 -> one cycle later Y=0, carryout=0.
//   3. A=3,B=2,carryin=1 -> Y=6, carryout=0 after one edge.
//   4. A=7,B=10,carryin=0 -> Y=1, carryout=1 (17 wraps).
//   5. A=15,B=15,carryin=1 -> Y=15, carryout=1; then A=15,B=0,carryin=1 -> Y=0, carryout=1 (full carry chain).
//   6. Exhaustive 4-bit sweep (512 combos) vs reference A+B+cin; assert rst mid-sweep -> outputs 0 async, resume correctly.
//   With CLA_OVERFLOW_EN: A=7,B=1,cin=0 -> overflow=1; A=8,B=8 -> overflow=1, Y=0, cout=1.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and types for the carry-lookahead adder.
// The lookahead is organised as 4-bit groups joined by a second-level carry unit.
package cla_pkg;

  localparam int CLA_GROUP_W       = 4;
  localparam int CLA_DEFAULT_WIDTH = 4;

  // Group generate/propagate pair handed from each slice to the second level.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

endpackage : cla_pkg

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead slice: two-level internal carries, group G/P for the next level.
// Group G and P depend only on a and b, so they never wait on cin.
module cla_group4
  import cla_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] a,
  input  logic [CLA_GROUP_W-1:0] b,
  input  logic                   cin,
  output logic [CLA_GROUP_W-1:0] sum,
  output logic                   G,
  output logic                   P
);

  logic [CLA_GROUP_W-1:0] g;
  logic [CLA_GROUP_W-1:0] p;
  logic [CLA_GROUP_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g, p and cin.
  assign c[0] = cin;
  assign c[1] = g[0]
              | (p[0] & cin);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign G = g[3]
           | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;

  assign sum = p ^ c;

endmodule : cla_group4

// File: rtl/carry_lookahead_adder.sv
// Registered WIDTH-bit adder A+B+carryin built from 4-bit lookahead groups and a
// second-level carry unit. Define CLA_OVERFLOW_EN to add the registered signed 'overflow' output.
module carry_lookahead_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] Y,
  output logic             carryout,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryin
`ifdef CLA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int NUM_GROUPS = WIDTH / CLA_GROUP_W;

  if ((WIDTH % CLA_GROUP_W) != 0 || WIDTH < CLA_GROUP_W) begin : g_bad_width
    $error("carry_lookahead_adder: WIDTH must be a positive multiple of 4");
  end

  gp_t  [NUM_GROUPS-1:0] gp;
  logic [NUM_GROUPS:0]   group_c;
  logic [WIDTH-1:0]      sum;
  logic                  prod;

  for (genvar j = 0; j < NUM_GROUPS; j++) begin : g_group
    cla_group4 u_group (
      .a   (A[j*CLA_GROUP_W +: CLA_GROUP_W]),
      .b   (B[j*CLA_GROUP_W +: CLA_GROUP_W]),
      .cin (group_c[j]),
      .sum (sum[j*CLA_GROUP_W +: CLA_GROUP_W]),
      .G   (gp[j].g),
      .P   (gp[j].p)
    );
  end

  // Second level: carry into group j is an OR of product terms over lower groups,
  // so no carry waits on another group's carry.
  always_comb begin
    // NOTE: every variable gets a value before any conditional use, so no latch is inferred.
    group_c    = '0;
    prod       = 1'b0;
    group_c[0] = carryin;
    for (int j = 1; j <= NUM_GROUPS; j++) begin
      for (int k = 0; k < j; k++) begin
        prod = gp[k].g;
        for (int m = k + 1; m < j; m++) begin
          prod = prod & gp[m].p;
        end
        group_c[j] = group_c[j] | prod;
      end
      prod = carryin;
      for (int m = 0; m < j; m++) begin
        prod = prod & gp[m].p;
      end
      group_c[j] = group_c[j] | prod;
    end
  end

`ifdef CLA_OVERFLOW_EN
  logic carry_into_msb;

  // sum[msb] = a^b^c_in, so the carry into the MSB falls out of the sum bit.
  assign carry_into_msb = sum[WIDTH-1] ^ A[WIDTH-1] ^ B[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
      overflow <= group_c[NUM_GROUPS] ^ carry_into_msb;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      Y        <= '0;
      carryout <= 1'b0;
    end else begin
      Y        <= sum;
      carryout <= group_c[NUM_GROUPS];
    end
  end

endmodule : carry_lookahead_adder

// File: tb/tb_carry_lookahead_adder.sv
// Directed and exhaustive checks of the 4-bit registered carry-lookahead adder,
// including asynchronous reset; overflow checks are included when CLA_OVERFLOW_EN is defined.
module tb_carry_lookahead_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A, B;
  logic       carryin;
  logic [3:0] Y;
  logic       carryout;
`ifdef CLA_OVERFLOW_EN
  logic       overflow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  carry_lookahead_adder #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .Y        (Y),
    .carryout (carryout),
    .A        (A),
    .B        (B),
    .carryin  (carryin)
`ifdef CLA_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Drive at the falling edge, let one rising edge capture, sample just after it.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin);
    @(negedge clk);
    A       = a;
    B       = b;
    carryin = cin;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] expected;

    // Reset asserted with non-zero inputs: outputs must clear without a clock edge.
    rst     = 1'b1;
    A       = 4'd9;
    B       = 4'd9;
    carryin = 1'b1;
    #2;
    check("reset_async_y", {12'h0, Y}, 16'h0);
    check("reset_async_cout", {15'h0, carryout}, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held_y", {12'h0, Y}, 16'h0);
    check("reset_held_cout", {15'h0, carryout}, 16'h0);
`ifdef CLA_OVERFLOW_EN
    check("reset_held_ovf", {15'h0, overflow}, 16'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    apply(4'd0, 4'd0, 1'b0);
    check("zero_y", {12'h0, Y}, 16'd0);
    check("zero_cout", {15'h0, carryout}, 16'd0);

    apply(4'd3, 4'd2, 1'b1);
    check("3p2p1_y", {12'h0, Y}, 16'd6);
    check("3p2p1_cout", {15'h0, carryout}, 16'd0);

    apply(4'd7, 4'd10, 1'b0);
    check("7p10_y", {12'h0, Y}, 16'd1);
    check("7p10_cout", {15'h0, carryout}, 16'd1);

    apply(4'd15, 4'd15, 1'b1);
    check("max_y", {12'h0, Y}, 16'd15);
    check("max_cout", {15'h0, carryout}, 16'd1);

    apply(4'd15, 4'd0, 1'b1);
    check("chain_y", {12'h0, Y}, 16'd0);
    check("chain_cout", {15'h0, carryout}, 16'd1);

`ifdef CLA_OVERFLOW_EN
    apply(4'd7, 4'd1, 1'b0);
    check("ovf_7p1", {15'h0, overflow}, 16'd1);
    check("ovf_7p1_y", {12'h0, Y}, 16'd8);
    apply(4'd8, 4'd8, 1'b0);
    check("ovf_8p8", {15'h0, overflow}, 16'd1);
    check("ovf_8p8_y", {12'h0, Y}, 16'd0);
    check("ovf_8p8_cout", {15'h0, carryout}, 16'd1);
    apply(4'd3, 4'd2, 1'b0);
    check("ovf_3p2", {15'h0, overflow}, 16'd0);
`endif

    // Exhaustive sweep, index = {a, b, cin}; reset pulse injected after a non-zero result.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] idx;
      idx = 9'(i);
      apply(idx[8:5], idx[4:1], idx[0]);
      expected = {1'b0, idx[8:5]} + {1'b0, idx[4:1]} + {4'b0, idx[0]};
      check("sweep", {11'h0, carryout, Y}, {11'h0, expected});
`ifdef CLA_OVERFLOW_EN
      check("sweep_ovf", {15'h0, overflow},
            {15'h0, (idx[8] == idx[4]) && (expected[3] != idx[8])});
`endif
      if (i == 300) begin
        // Registered result here is 9+6+0 = 15, so a clear is observable.
        rst = 1'b1;
        #1;
        check("midsweep_rst_y", {12'h0, Y}, 16'h0);
        check("midsweep_rst_cout", {15'h0, carryout}, 16'h0);
        @(posedge clk);
        #1;
        check("midsweep_rst_held", {11'h0, carryout, Y}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_carry_lookahead_adder
